// File: rtl/mvm_seq_ctrl.sv
// mvm_seq_ctrl
//   Sequencer for one matrix-vector multiply on a XBAR_SIZE-row crossbar.
//   It walks the rows in order. For each row it fetches the activation. A
//   zero activation (skip=1) ends the row at once. Any other row goes through
//   READ, CALC and SUM, one cycle each. After the last row the sequencer
//   pulses DONE. From IDLE it can also run a single weight-programming cycle
//   (PROG).
//
// Ports
//   clk          : clock; all state changes happen on its rising edge
//   reset        : synchronous reset, active high
//   start        : request an MVM; looked at only in IDLE
//   prog_req     : request a weight write; looked at only in IDLE; wins over start
//   abort        : cancel an MVM that is running (READY..SUM)
//   skip         : the activation of the current row is zero; looked at only in FETCH
//   get_ready    : clear strobe to the datapath (READY)
//   fetch        : activation fetch strobe (FETCH)
//   rd_en        : weight-row read strobe (READ)
//   calc         : multiply strobe (CALC)
//   up_sum       : accumulate strobe (SUM)
//   prog_wt      : weight-memory write strobe (PROG)
//   mvm_done     : output-latch strobe to the datapath (DONE)
//   counter      : index of the current row
//   busy         : high in every state except IDLE
//   done         : one-cycle completion pulse to the requester (DONE)
//   o_dbg_state  : raw FSM state, for debug and checkers
//
// Handshake: start and prog_req are level-sampled requests. They are taken
// only on an edge where busy=0, and they are never queued. done is a
// single-cycle pulse with no back-pressure.

module mvm_seq_ctrl #(
  parameter int XBAR_SIZE = 128,
  parameter int N_SIZE    = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              prog_req,
  input  logic              abort,
  input  logic              skip,
  output logic              get_ready,
  output logic              fetch,
  output logic              rd_en,
  output logic              calc,
  output logic              up_sum,
  output logic              prog_wt,
  output logic              mvm_done,
  output logic [N_SIZE-1:0] counter,
  output logic              busy,
  output logic              done,
  output logic [2:0]        o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PROG  = 3'd1,
    S_READY = 3'd2,
    S_FETCH = 3'd3,
    S_READ  = 3'd4,
    S_CALC  = 3'd5,
    S_SUM   = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [N_SIZE-1:0] LAST_ROW = N_SIZE'(XBAR_SIZE - 1);

  state_t              r_state;
  state_t              w_next_state;
  logic [N_SIZE-1:0]   r_counter;
  logic [N_SIZE-1:0]   w_next_counter;
  logic                w_last_row;

  assign w_last_row = (r_counter == LAST_ROW);

  // State register. The row counter lives here too because it moves only
  // together with state transitions.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_counter <= '0;
    end else begin
      r_state   <= w_next_state;
      r_counter <= w_next_counter;
    end
  end

  // Next-state and next-counter logic. Abort is checked first in READY..SUM,
  // so it also beats the end-of-row step on the last row. On abort the
  // counter keeps its value.
  always_comb begin
    w_next_state   = r_state;
    w_next_counter = r_counter;
    case (r_state)
      S_IDLE: begin
        if (prog_req) begin
          w_next_state = S_PROG;
        end else if (start) begin
          w_next_state   = S_READY;
          w_next_counter = '0;
        end
      end
      S_PROG: w_next_state = S_IDLE;
      S_READY: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else begin
          w_next_state   = S_FETCH;
          w_next_counter = '0;
        end
      end
      S_FETCH: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (!skip) begin
          w_next_state = S_READ;
        end else if (w_last_row) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state   = S_FETCH;
          w_next_counter = r_counter + N_SIZE'(1);
        end
      end
      S_READ:  w_next_state = abort ? S_IDLE : S_CALC;
      S_CALC:  w_next_state = abort ? S_IDLE : S_SUM;
      S_SUM: begin
        if (abort) begin
          w_next_state = S_IDLE;
        end else if (w_last_row) begin
          w_next_state = S_DONE;
        end else begin
          w_next_state   = S_FETCH;
          w_next_counter = r_counter + N_SIZE'(1);
        end
      end
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are decoded one-hot from the state, so at most one datapath
  // strobe can be active in any cycle.
  always_comb begin
    get_ready = 1'b0;
    fetch     = 1'b0;
    rd_en     = 1'b0;
    calc      = 1'b0;
    up_sum    = 1'b0;
    prog_wt   = 1'b0;
    mvm_done  = 1'b0;
    done      = 1'b0;
    case (r_state)
      S_PROG:  prog_wt   = 1'b1;
      S_READY: get_ready = 1'b1;
      S_FETCH: fetch     = 1'b1;
      S_READ:  rd_en     = 1'b1;
      S_CALC:  calc      = 1'b1;
      S_SUM:   up_sum    = 1'b1;
      S_DONE: begin
        mvm_done = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy        = (r_state != S_IDLE);
  assign counter     = r_counter;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mvm_seq_ctrl.sv
// Testbench for mvm_seq_ctrl with XBAR_SIZE=4.
// The model predicts, from the activation table, the exact output vector for
// every cycle of a transaction. Each row gives either a single FETCH (zero
// activation) or FETCH/READ/CALC/SUM. The transaction opens with READY and
// closes with DONE. An abort or reset drops the rest of the prediction.

module tb_mvm_seq_ctrl;

  localparam int XS = 4;
  localparam int NS = 2;

  logic          clk = 1'b0;
  logic          reset, start, prog_req, abort, skip;
  logic          get_ready, fetch, rd_en, calc, up_sum, prog_wt, mvm_done;
  logic [NS-1:0] counter;
  logic          busy, done;
  logic [2:0]    dbg_state;

  always #5 clk = ~clk;

  mvm_seq_ctrl #(.XBAR_SIZE(XS), .N_SIZE(NS)) dut (
    .clk(clk), .reset(reset), .start(start), .prog_req(prog_req),
    .abort(abort), .skip(skip), .get_ready(get_ready), .fetch(fetch),
    .rd_en(rd_en), .calc(calc), .up_sum(up_sum), .prog_wt(prog_wt),
    .mvm_done(mvm_done), .counter(counter), .busy(busy), .done(done),
    .o_dbg_state(dbg_state)
  );

  // Activation source. Outside FETCH, skip is held high so that it must be ignored.
  int act [4];
  assign skip = fetch ? (act[counter] == 0) : 1'b1;

  // ---------------- model ----------------
  typedef enum {K_IDLE, K_PROG, K_READY, K_FETCH, K_READ, K_CALC, K_SUM, K_DONE} kind_t;

  // Vector: {busy, done, mvm_done, prog_wt, up_sum, calc, rd_en, fetch, get_ready, counter[1:0]}
  function automatic logic [10:0] mk(kind_t k, logic [1:0] c);
    logic [10:0] v;
    v = '0;
    v[1:0] = c;
    case (k)
      K_PROG:  v[7] = 1'b1;
      K_READY: v[2] = 1'b1;
      K_FETCH: v[3] = 1'b1;
      K_READ:  v[4] = 1'b1;
      K_CALC:  v[5] = 1'b1;
      K_SUM:   v[6] = 1'b1;
      K_DONE:  begin v[8] = 1'b1; v[9] = 1'b1; end
      default: ;
    endcase
    v[10] = (k != K_IDLE);
    return v;
  endfunction

  logic [10:0] exp_q [$];
  logic [1:0]  hold_cnt;
  logic [10:0] dut_vec, cmp_e;
  bit          chk_en = 1'b0;
  int          n_checks = 0;
  int          n_errors = 0;

  assign dut_vec = {busy, done, mvm_done, prog_wt, up_sum, calc, rd_en, fetch, get_ready, counter};

  task automatic chk(input string name, input logic [63:0] a, input logic [63:0] e);
    n_checks++;
    if (a !== e) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, a, e, $time);
    end
  endtask

  // Compare process. It runs on every cycle once reset has been seen.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_q.size() > 0) cmp_e = exp_q.pop_front();
      else cmp_e = mk(K_IDLE, hold_cnt);
      chk("cycle_outputs", 64'(dut_vec), 64'(cmp_e));
    end
  end

  // Keep the prediction for the current cycle and drop the rest.
  task automatic truncate_model();
    logic [10:0] f;
    if (exp_q.size() > 0) begin
      f = exp_q[0];
      exp_q.delete();
      exp_q.push_back(f);
      hold_cnt = f[1:0];
    end
  endtask

  // ---------------- driver ----------------
  // Entry and exit points are always posedge+1.
  task automatic run_mvm(input int a0, input int a1, input int a2, input int a3,
                         input int abort_cyc, input int reset_cyc, input int busy_cyc,
                         input int exp_len, input int exp_done,
                         input logic [63:0] e_fetch, input logic [63:0] e_rd,
                         input logic [63:0] e_calc, input logic [63:0] e_up,
                         input string tag);
    int cyc, done_cyc;
    logic [63:0] fm, rm, cm, um;
    act[0] = a0; act[1] = a1; act[2] = a2; act[3] = a3;
    exp_q.push_back(mk(K_IDLE, hold_cnt));
    exp_q.push_back(mk(K_READY, 2'd0));
    for (int r = 0; r < XS; r++) begin
      exp_q.push_back(mk(K_FETCH, 2'(r)));
      if (act[r] != 0) begin
        exp_q.push_back(mk(K_READ, 2'(r)));
        exp_q.push_back(mk(K_CALC, 2'(r)));
        exp_q.push_back(mk(K_SUM, 2'(r)));
      end
    end
    exp_q.push_back(mk(K_DONE, 2'(XS - 1)));
    hold_cnt = 2'(XS - 1);
    chk({tag, "_model_len"}, 64'(exp_q.size()), 64'(exp_len));
    start = 1'b1;
    cyc = 0; done_cyc = -1;
    fm = '0; rm = '0; cm = '0; um = '0;
    forever begin
      @(negedge clk);
      if (fetch)  fm |= (64'd1 << cyc);
      if (rd_en)  rm |= (64'd1 << cyc);
      if (calc)   cm |= (64'd1 << cyc);
      if (up_sum) um |= (64'd1 << cyc);
      if (done && done_cyc < 0) done_cyc = cyc;
      @(posedge clk); #1;
      cyc++;
      start = 1'b0; prog_req = 1'b0; abort = 1'b0;
      if (reset_cyc >= 0 && cyc == reset_cyc + 1) begin
        reset = 1'b0;
        break;
      end
      if (done_cyc >= 0) break;
      if (abort_cyc >= 0 && cyc == abort_cyc + 2) break;
      if (cyc >= 40) begin
        n_checks++; n_errors++;
        $display("FAIL %s_timeout: no completion after %0d cycles, required within 40", tag, cyc);
        break;
      end
      if (cyc == abort_cyc) begin abort = 1'b1; truncate_model(); end
      if (cyc == reset_cyc) begin reset = 1'b1; truncate_model(); hold_cnt = 2'd0; end
      if (cyc == busy_cyc)  begin start = 1'b1; prog_req = 1'b1; end
    end
    chk({tag, "_done_cycle"}, 64'(done_cyc), 64'(exp_done));
    chk({tag, "_fetch_cycles"}, fm, e_fetch);
    chk({tag, "_rd_cycles"},    rm, e_rd);
    chk({tag, "_calc_cycles"},  cm, e_calc);
    chk({tag, "_sum_cycles"},   um, e_up);
  endtask

  // Start and prog_req arrive together in IDLE. Then both are pulsed while PROG is busy.
  task automatic prog_test();
    logic [63:0] pm, gm;
    int cyc;
    exp_q.push_back(mk(K_IDLE, hold_cnt));
    exp_q.push_back(mk(K_PROG, hold_cnt));
    start = 1'b1; prog_req = 1'b1;
    pm = '0; gm = '0;
    for (cyc = 0; cyc < 5; ) begin
      @(negedge clk);
      if (prog_wt)   pm |= (64'd1 << cyc);
      if (get_ready) gm |= (64'd1 << cyc);
      @(posedge clk); #1;
      cyc++;
      start    = (cyc == 1);
      prog_req = (cyc == 1);
    end
    chk("prog_cycles", pm, 64'h2);
    chk("prog_no_ready", gm, 64'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; prog_req = 1'b0; abort = 1'b0;
    act[0] = 0; act[1] = 0; act[2] = 0; act[3] = 0;
    hold_cnt = 2'd0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // All rows non-zero, with start/prog_req pulsed while busy.
    run_mvm(1, 1, 1, 1, -1, -1, 5, 19, 18,
            64'h4444, 64'h8888, 64'h11110, 64'h22220, "all_nz");
    @(posedge clk); #1;
    // All rows zero.
    run_mvm(0, 0, 0, 0, -1, -1, -1, 7, 6,
            64'h3C, 64'h0, 64'h0, 64'h0, "all_zero");
    @(posedge clk); #1;
    // Activations {0,5,0,7}.
    run_mvm(0, 5, 0, 7, -1, -1, -1, 13, 12,
            64'h18C, 64'h210, 64'h420, 64'h840, "mixed");
    @(posedge clk); #1;
    prog_test();
    // Abort in cycle 7 (READ of row 1).
    run_mvm(1, 1, 1, 1, 7, -1, -1, 19, -1,
            64'h44, 64'h88, 64'h10, 64'h20, "abort");
    chk("abort_counter_hold", 64'(counter), 64'd1);
    chk("abort_not_busy", 64'(busy), 64'd0);
    run_mvm(1, 1, 1, 1, -1, -1, -1, 19, 18,
            64'h4444, 64'h8888, 64'h11110, 64'h22220, "after_abort");
    @(posedge clk); #1;
    // Reset in cycle 9 during CALC of row 2; start again right after reset drops.
    run_mvm(0, 5, 5, 5, -1, 9, -1, 16, -1,
            64'h8C, 64'h110, 64'h220, 64'h40, "reset_mid");
    chk("reset_counter", 64'(counter), 64'd0);
    run_mvm(1, 1, 1, 1, -1, -1, -1, 19, 18,
            64'h4444, 64'h8888, 64'h11110, 64'h22220, "after_reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
